exe_mul_sequencer: RTL

//  Iterative radix-2 shift-add sequencer for ARM MUL/MLA, beside the EXE stage ALU.

---
 rtl/exe_mul_sequencer_if.sv | 34 +++
 rtl/exe_mul_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/exe_mul_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | exe_mul_sequencer_if : EXE-stage <-> multiply sequencer handshake bundle  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface exe_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             accumulate;
  logic [WIDTH-1:0] val_rm;
  logic [WIDTH-1:0] val_rs;
  logic [WIDTH-1:0] val_rn;
  logic [3:0]       status_in;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       status_out;

  modport master (
    output start, accumulate, val_rm, val_rs, val_rn, status_in, flush,
    input  stall, done, result, status_out
  );

  modport slave (
    input  start, accumulate, val_rm, val_rs, val_rn, status_in, flush,
    output stall, done, result, status_out
  );
endinterface

`default_nettype wire

// File: rtl/exe_mul_sequencer.sv
// +--------------------------------------------------------------------------+
// | exe_mul_sequencer : radix-2 shift-add MUL/MLA sequencer with N/Z flags   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module exe_mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  exe_mul_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [1:0]       cv_q,     cv_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       status_q, status_d;

  logic             w_accept;
  logic [WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0] w_mplier_shift;
  logic             w_early;
  logic             w_last;

  assign w_accept       = (state_q == ST_IDLE) && bus.start && !bus.flush;
  assign w_acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign w_mplier_shift = mplier_q >> 1;

  // Early exit only needs the multiplier bits still to be consumed.
  generate
    if (EARLY_EXIT) begin : g_early_exit
      assign w_early = (w_mplier_shift == '0);
    end else begin : g_full_run
      assign w_early = 1'b0;
    end
  endgenerate

  assign w_last = (cnt_q == CNT_W'(WIDTH - 1)) || w_early;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cv_d     = cv_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          mcand_d  = bus.val_rm;
          mplier_d = bus.val_rs;
          acc_d    = bus.accumulate ? bus.val_rn : '0;
          cv_d     = bus.status_in[1:0];
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A flush on the final step still wins: no result is published.
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = w_acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = w_mplier_shift;
          cnt_d    = cnt_q + CNT_W'(1);
          if (w_last) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = w_acc_step;
            status_d = {w_acc_step[WIDTH-1], (w_acc_step == '0), cv_q};
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cv_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cv_q     <= cv_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  // Combinational so the issuing cycle already freezes the pipeline.
  assign bus.stall      = w_accept || (state_q == ST_BUSY);
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.status_out = status_q;

endmodule

`default_nettype wire
